// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO sequencer bus: op issue, flush, stall/done handshake and
// the architectural {HI,LO} read port.
interface hilo_muldiv_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] hilo;
  logic [31:0] busy_cnt;

  modport master (
    output start, op, a, b, flush,
    input  stall, done, hilo, busy_cnt
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, done, hilo, busy_cnt
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning the HI/LO pair; stalls EX until HI/LO is final.
// Optional stall-cycle counter on busy_cnt when HILO_BUSY_CNT_EN is defined.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV  = 3'd3,
    OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO  = 3'd6, OP_NOP7 = 3'd7
  } op_e;

  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] quo;
  } div_t;

  // The start cycle counts toward latency, so busy states run one cycle short.
  localparam logic [4:0] MUL_LOAD = (MUL_CYCLES > 1) ? 5'(MUL_CYCLES - 2) : 5'd0;
  localparam logic [4:0] DIV_LOAD = 5'd30;

  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {{32{sgn & x[31]}}, x};
    ye = {{32{sgn & y[31]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic div_t div_step(input logic [31:0] rem, input logic [31:0] quo,
                                    input logic [31:0] dvs);
    logic [32:0] sh;
    logic [32:0] diff;
    div_t        r;
    sh   = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    if (!diff[32]) begin
      r.rem = diff[31:0];
      r.quo = {quo[30:0], 1'b1};
    end else begin
      r.rem = sh[31:0];
      r.quo = {quo[30:0], 1'b0};
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] a_q, a_d;    // multiplicand, or dividend/quotient shift register
  logic [31:0] b_q, b_d;    // multiplier, or |divisor|
  logic [31:0] rem_q, rem_d;
  logic [63:0] hilo_q, hilo_d;
  logic        stall_c;
  logic        done_c;
  logic        stall_o;

  op_e         op_in;
  logic        op_sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        in_div;
  div_t        step;

  assign op_in  = op_e'(bus.op);
  assign op_sgn = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_abs  = abs32(bus.a, op_sgn);
  assign b_abs  = abs32(bus.b, op_sgn);
  assign in_div = (state_q == S_DIV);
  assign step   = in_div ? div_step(rem_q, a_q, b_q) : div_step(32'd0, a_abs, b_abs);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hilo_d  = hilo_q;
    stall_c = 1'b0;
    done_c  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done_c  = (state_q == S_DONE);
        state_d = S_IDLE;
        if (bus.start && !bus.flush) begin
          unique case (op_in)
            OP_MTHI: hilo_d[63:32] = bus.a;
            OP_MTLO: hilo_d[31:0]  = bus.a;
            OP_MULT, OP_MULTU: begin
              stall_c = 1'b1;
              sgn_d   = op_sgn;
              a_d     = bus.a;
              b_d     = bus.b;
              if (MUL_CYCLES == 1) begin
                hilo_d  = mul64(bus.a, bus.b, op_sgn);
                state_d = S_DONE;
              end else begin
                cnt_d   = MUL_LOAD;
                state_d = S_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              stall_c = 1'b1;
              if (bus.b == 32'd0) begin
                hilo_d  = {bus.a, 32'hFFFF_FFFF};
                state_d = S_DONE;
              end else begin
                q_neg_d = op_sgn & (bus.a[31] ^ bus.b[31]);
                r_neg_d = op_sgn & bus.a[31];
                rem_d   = step.rem;
                a_d     = step.quo;
                b_d     = b_abs;
                cnt_d   = DIV_LOAD;
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        stall_c = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          hilo_d  = mul64(a_q, b_q, sgn_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DIV: begin
        stall_c = 1'b1;
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          hilo_d  = {r_neg_q ? -step.rem : step.rem, q_neg_q ? -step.quo : step.quo};
          state_d = S_DONE;
        end else begin
          rem_d = step.rem;
          a_d   = step.quo;
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hilo_q  <= hilo_d;
    end
  end

  // stall is partly combinational from start, so reset must gate it directly.
  assign stall_o  = stall_c & ~rst;
  assign bus.stall = stall_o;
  assign bus.done  = done_c;
  assign bus.hilo  = hilo_q;

`ifdef HILO_BUSY_CNT_EN
  logic [31:0] busy_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else if (stall_o) begin
      busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;
`else
  assign bus.busy_cnt = '0;
`endif

endmodule
